pcie_ss_ctrl_bridge: RTL and testbench



---
 rtl/pcie_ss_ctrl_bridge.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pcie_ss_ctrl_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_ss_ctrl_bridge.sv
// pcie_ss_ctrl_bridge
// Turns each level-held command from pcie_csr into exactly one AXI4-lite
// transaction on the PCIe SS control/status port. Returns read data and
// completion status, and aborts a transaction whose target stops responding.
module pcie_ss_ctrl_bridge #(
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Command side (pcie_csr)
  input  logic [1:0]            i_ss_ctrl_cmd,
  input  logic [ADDR_WIDTH-1:0] i_ss_ctrl_addr,
  input  logic [31:0]           i_ss_ctrl_writedata,
  output logic [31:0]           o_ss_readdata,
  output logic                  o_ss_ack,
  output logic                  o_ss_error,
  // AXI4-lite write address channel
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  // AXI4-lite write data channel
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  // AXI4-lite write response channel
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  // AXI4-lite read address channel
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  // AXI4-lite read data channel
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // A limit of zero turns the watchdog off entirely.
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                  state_r;
  logic [CNT_W-1:0]        tmo_cnt_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;
  logic [31:0]             wdata_r;
  logic [31:0]             readdata_r;
  logic                    ack_r;
  logic                    error_r;

  logic                    tmo_hit_s;
  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    aw_done_s;
  logic                    w_done_s;
  logic                    b_hs_s;
  logic                    ar_hs_s;
  logic                    r_hs_s;

  // Handshake qualifiers; a channel counts as done once its valid has dropped
  // or its handshake is happening in this cycle.
  always_comb begin
    aw_hs_s   = awvalid_r & m_axi_awready;
    w_hs_s    = wvalid_r & m_axi_wready;
    aw_done_s = (~awvalid_r) | m_axi_awready;
    w_done_s  = (~wvalid_r) | m_axi_wready;
    b_hs_s    = bready_r & m_axi_bvalid;
    ar_hs_s   = arvalid_r & m_axi_arready;
    r_hs_s    = rready_r & m_axi_rvalid;
  end

  // Watchdog limit detection for the transaction currently in flight.
  always_comb begin
    tmo_hit_s = 1'b0;
    if (TMO_EN) begin
      tmo_hit_s = (tmo_cnt_r == TMO_LIMIT);
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Command FSM: captures the command, runs one AXI transaction, then holds
  // ack until the command is withdrawn so a held command is never replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tmo_cnt_r  <= {CNT_W{1'b0}};
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      awaddr_r   <= {ADDR_WIDTH{1'b0}};
      araddr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= 32'h0000_0000;
      readdata_r <= 32'h0000_0000;
      ack_r      <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= {CNT_W{1'b0}};
          case (i_ss_ctrl_cmd)
            CMD_WRITE: begin
              awaddr_r  <= i_ss_ctrl_addr;
              wdata_r   <= i_ss_ctrl_writedata;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= ST_WR_REQ;
            end
            CMD_READ: begin
              araddr_r  <= i_ss_ctrl_addr;
              arvalid_r <= 1'b1;
              state_r   <= ST_RD_REQ;
            end
            CMD_RSVD: begin
              ack_r   <= 1'b1;
              error_r <= 1'b1;
              state_r <= ST_DONE;
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end

        ST_WR_REQ: begin
          if (tmo_hit_s) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            ack_r     <= 1'b1;
            error_r   <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
            if (aw_hs_s) begin
              awvalid_r <= 1'b0;
            end
            if (w_hs_s) begin
              wvalid_r <= 1'b0;
            end
            if (aw_done_s && w_done_s) begin
              bready_r <= 1'b1;
              state_r  <= ST_WR_RESP;
            end
          end
        end

        ST_WR_RESP: begin
          if (b_hs_s) begin
            bready_r <= 1'b0;
            ack_r    <= 1'b1;
            error_r  <= (m_axi_bresp != RESP_OKAY);
            state_r  <= ST_DONE;
          end else if (tmo_hit_s) begin
            bready_r <= 1'b0;
            ack_r    <= 1'b1;
            error_r  <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end

        ST_RD_REQ: begin
          if (tmo_hit_s) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            ack_r     <= 1'b1;
            error_r   <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
            if (ar_hs_s) begin
              arvalid_r <= 1'b0;
              rready_r  <= 1'b1;
              state_r   <= ST_RD_RESP;
            end
          end
        end

        ST_RD_RESP: begin
          if (r_hs_s) begin
            // Data is kept even on SLVERR/DECERR so software can inspect it.
            rready_r   <= 1'b0;
            readdata_r <= m_axi_rdata;
            ack_r      <= 1'b1;
            error_r    <= (m_axi_rresp != RESP_OKAY);
            state_r    <= ST_DONE;
          end else if (tmo_hit_s) begin
            rready_r <= 1'b0;
            ack_r    <= 1'b1;
            error_r  <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end

        ST_DONE: begin
          if (i_ss_ctrl_cmd == CMD_IDLE) begin
            ack_r   <= 1'b0;
            error_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end

        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          ack_r     <= 1'b0;
          error_r   <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ss_readdata = readdata_r;
  assign o_ss_ack      = ack_r;
  assign o_ss_error    = error_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_bready  = bready_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_pcie_ss_ctrl_bridge.sv
// Scoreboard bench for pcie_ss_ctrl_bridge: directed commands push expected
// completions; a monitor pops and compares on every rising ack.
`timescale 1ns/1ps
module tb_pcie_ss_ctrl_bridge;
  localparam int AW  = 20;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cmd;
  logic [AW-1:0] addr;
  logic [31:0]   wdata_in;
  logic [31:0]   readdata;
  logic          ack, err;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid_tgt, rvalid_stray, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata, rdata_tgt;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  pcie_ss_ctrl_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ss_ctrl_cmd(cmd), .i_ss_ctrl_addr(addr), .i_ss_ctrl_writedata(wdata_in),
    .o_ss_readdata(readdata), .o_ss_ack(ack), .o_ss_error(err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_rvalid(rvalid_tgt | rvalid_stray), .m_axi_rready(rready),
    .m_axi_rdata(rvalid_stray ? 32'h0BAD_F00D : rdata_tgt), .m_axi_rresp(rresp)
  );

  typedef struct {
    logic [31:0]   rd;
    logic          err;
    int            lat;
    int            n_aw, n_w, n_ar;
    bit            chk_wr, chk_rd;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, issue_cyc = 0, clear_cyc = 0;
  int   exp_aw = 0, exp_w = 0, exp_ar = 0;
  logic [31:0] model_rd = 32'h0;

  // target configuration (written by stimulus only)
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // target state and beat records (written by target process only)
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int aw_beats = 0, w_beats = 0, ar_beats = 0;
  bit aw_got = 0, w_got = 0, b_pend = 0, b_taken = 0, r_pend = 0, r_taken = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [31:0]   last_wdata = '0;
  logic [3:0]    last_wstrb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_error"}, err, 1'b0);
    check({tag, "_readdata"}, readdata, 32'h0);
    check({tag, "_valid_ready"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check({tag, "_awaddr"}, awaddr, 20'h0);
    check({tag, "_araddr"}, araddr, 20'h0);
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_wstrb"}, wstrb, 4'hF);
  endtask

  // AXI4-lite target model: programmable per-channel delays, records beats.
  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
    rvalid_tgt = 0; rresp = 0; rdata_tgt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid_tgt = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; b_taken = 0; r_pend = 0; r_taken = 0;
      end else begin
        // B channel
        if (b_taken) begin bvalid = 0; b_taken = 0; end
        else if (b_pend) begin
          if (b_cnt >= b_dly) begin bvalid = 1; bresp = cfg_bresp; b_pend = 0; end
          else b_cnt++;
        end
        if (bvalid && bready) b_taken = 1;
        // R channel
        if (r_taken) begin rvalid_tgt = 0; r_taken = 0; end
        else if (r_pend) begin
          if (r_cnt >= r_dly) begin rvalid_tgt = 1; rdata_tgt = cfg_rdata; rresp = cfg_rresp; r_pend = 0; end
          else r_cnt++;
        end
        if (rvalid_tgt && rready) r_taken = 1;
        // AW channel
        if (awready) awready = 0;
        else if (awvalid) begin
          if (aw_cnt >= aw_dly) begin
            awready = 1; aw_cnt = 0; aw_beats++; last_awaddr = awaddr; aw_got = 1;
          end else aw_cnt++;
        end else aw_cnt = 0;
        // W channel
        if (wready) wready = 0;
        else if (wvalid) begin
          if (w_cnt >= w_dly) begin
            wready = 1; w_cnt = 0; w_beats++; last_wdata = wdata; last_wstrb = wstrb; w_got = 1;
          end else w_cnt++;
        end else w_cnt = 0;
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
        // AR channel
        if (arready) arready = 0;
        else if (arvalid) begin
          if (ar_cnt >= ar_dly) begin
            arready = 1; ar_cnt = 0; ar_beats++; last_araddr = araddr; r_pend = 1; r_cnt = 0;
          end else ar_cnt++;
        end else ar_cnt = 0;
      end
    end
  end

  // Monitor: compare every completion against the scoreboard head.
  initial begin
    exp_t e;
    logic ack_q;
    ack_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) ack_q = 1'b0;
      else begin
        if (ack && !ack_q) begin
          if (sb.size() == 0) check("unexpected_ack", 1'b1, 1'b0);
          else begin
            e = sb.pop_front();
            check("readdata", readdata, e.rd);
            check("error", err, e.err);
            check("ack_latency", cyc - issue_cyc, e.lat);
            check("aw_beats", aw_beats, e.n_aw);
            check("w_beats", w_beats, e.n_w);
            check("ar_beats", ar_beats, e.n_ar);
            check("axi_idle_at_ack", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
            if (e.chk_wr) begin
              check("awaddr", last_awaddr, e.addr);
              check("wdata", last_wdata, e.wd);
              check("wstrb", last_wstrb, 4'hF);
            end
            if (e.chk_rd) check("araddr", last_araddr, e.addr);
          end
        end
        if (!ack && ack_q) begin
          check("ack_drop_latency", cyc - clear_cyc, 1);
          check("error_cleared", err, 1'b0);
        end
        ack_q = ack;
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic x_err, input int x_lat, input bit beats, input bit push);
    exp_t e;
    if (beats && c == 2'b01) begin exp_aw++; exp_w++; end
    if (beats && c == 2'b10) exp_ar++;
    e.rd = model_rd; e.err = x_err; e.lat = x_lat;
    e.n_aw = exp_aw; e.n_w = exp_w; e.n_ar = exp_ar;
    e.chk_wr = beats && (c == 2'b01); e.chk_rd = beats && (c == 2'b10);
    e.addr = a; e.wd = d;
    if (push) sb.push_back(e);
    @(negedge clk);
    cmd = c; addr = a; wdata_in = d; issue_cyc = cyc;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (!ack && n < budget) begin @(negedge clk); n++; end
    if (!ack) check("ack_wait_budget", 1'b0, 1'b1);
  endtask

  task automatic clear_cmd();
    @(negedge clk);
    cmd = 2'b00; clear_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rvalid_stray = 0;
    cmd = 2'b00; addr = '0; wdata_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero-wait write
    issue(2'b01, 20'h00104, 32'hA5A5_1234, 1'b0, 3, 1, 1);
    wait_ack(40); clear_cmd();

    // read with arready delayed 3 cycles
    ar_dly = 3; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00; model_rd = 32'hDEAD_BEEF;
    issue(2'b10, 20'h00008, 32'h0, 1'b0, 6, 1, 1);
    wait_ack(40); clear_cmd();

    // zero-wait read
    ar_dly = 0; cfg_rdata = 32'h0123_4567; model_rd = 32'h0123_4567;
    issue(2'b10, 20'h00010, 32'h0, 1'b0, 3, 1, 1);
    wait_ack(40); clear_cmd();

    // split write handshake; inputs change after capture and must be ignored
    w_dly = 1; aw_dly = 3; b_dly = 2;
    issue(2'b01, 20'h0A0C4, 32'h5555_AAAA, 1'b0, 8, 1, 1);
    @(negedge clk); addr = 20'hFFFFF; wdata_in = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    check("split_wvalid_dropped", wvalid, 1'b0);
    check("split_awvalid_held", awvalid, 1'b1);
    wait_ack(40); clear_cmd();
    w_dly = 0; aw_dly = 0; b_dly = 0;

    // read SLVERR: data still latched
    cfg_rdata = 32'h1357_2468; cfg_rresp = 2'b10; model_rd = 32'h1357_2468;
    issue(2'b10, 20'h00020, 32'h0, 1'b1, 3, 1, 1);
    wait_ack(40); clear_cmd();
    cfg_rresp = 2'b00;

    // write EXOKAY counts as error
    cfg_bresp = 2'b01;
    issue(2'b01, 20'h00300, 32'h0F0F_0F0F, 1'b1, 3, 1, 1);
    wait_ack(40); clear_cmd();
    cfg_bresp = 2'b00;

    // reserved command: immediate error, no AXI traffic
    issue(2'b11, 20'h00400, 32'h1111_1111, 1'b1, 1, 0, 1);
    wait_ack(40); clear_cmd();

    // timeout with arready stuck low, then a stray R beat
    ar_dly = 1000000;
    issue(2'b10, 20'h00ABC, 32'h0, 1'b1, TMO + 1, 0, 1);
    wait_ack(40);
    rvalid_stray = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_rready_low", rready, 1'b0);
    end
    rvalid_stray = 0;
    check("stray_readdata_kept", readdata, model_rd);
    clear_cmd();
    ar_dly = 0;

    // command held for 50 cycles after ack gives exactly one write
    issue(2'b01, 20'h00200, 32'hCAFE_0001, 1'b0, 3, 1, 1);
    wait_ack(40);
    repeat (50) @(negedge clk);
    check("hold_aw_once", aw_beats, exp_aw);
    check("hold_w_once", w_beats, exp_w);
    check("hold_ack_level", ack, 1'b1);
    clear_cmd();

    // asynchronous reset while waiting in RD_RESP
    r_dly = 1000000;
    issue(2'b10, 20'h00040, 32'h0, 1'b0, 0, 1, 0);
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    check("reach_rd_resp", rready, 1'b1);
    rst_n = 1'b0; cmd = 2'b00;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; model_rd = 32'h0; r_dly = 0;
    repeat (2) @(negedge clk);

    // recovery read after reset
    cfg_rdata = 32'h8765_4321; model_rd = 32'h8765_4321;
    issue(2'b10, 20'h00044, 32'h0, 1'b0, 3, 1, 1);
    wait_ack(40); clear_cmd();

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
